// File: rtl/reg_wr_arbiter.sv
// Register-file write-port arbiter: writeback has priority, long-latency results queue in a FIFO.
// Optional macro LU_BYPASS_EN lets a result go straight to the write port when the port and FIFO are idle.
module reg_wr_arbiter #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en,
   input  logic [4:0]  wb_add,
   input  logic [31:0] wb_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_add,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   input  logic        iss_en,
   input  logic [4:0]  iss_add,
   input  logic        rd1_en,
   input  logic [4:0]  rd1_add,
   input  logic        rd2_en,
   input  logic [4:0]  rd2_add,
   output logic        hazard,
   output logic        stall_req,
   output logic        w_en,
   output logic [4:0]  w_add,
   output logic [31:0] w_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [4:0]  add;
      logic [31:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [31:0]     busy_q, busy_d;

   entry_t          head;
   logic            wb_act, empty, full, pop, push, byp, starved;

   assign head    = mem_q[rd_ptr_q];
   assign wb_act  = wb_en && (wb_add != '0);
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign starved = (starve_q == SW'(STARVE_MAX));

   always_comb begin
      byp = 1'b0;
`ifdef LU_BYPASS_EN
      byp = !rst && empty && !wb_act && lu_valid && (lu_add != '0);
`endif
      pop  = !rst && !wb_act && !empty;
      // lu_add==0 is acknowledged but dropped, so it never reaches the FIFO
      push = !rst && lu_valid && !full && (lu_add != '0) && !byp;
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

      starve_d = starve_q;
      if (empty || pop)
         starve_d = '0;
      else if (!starved)
         starve_d = starve_q + SW'(1);

      // set is applied last so a same-cycle issue to the popped register wins
      busy_d = busy_q;
      if (pop)
         busy_d[head.add] = 1'b0;
      if (byp)
         busy_d[lu_add] = 1'b0;
      if (iss_en && (iss_add != '0))
         busy_d[iss_add] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         busy_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         busy_q   <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= '{add: lu_add, data: lu_data};
   end

   always_comb begin
      w_en   = 1'b0;
      w_add  = '0;
      w_data = '0;
      if (!rst) begin
         if (wb_act) begin
            w_en   = 1'b1;
            w_add  = wb_add;
            w_data = wb_data;
         end else if (!empty) begin
            w_en   = 1'b1;
            w_add  = head.add;
            w_data = head.data;
         end else if (byp) begin
            w_en   = 1'b1;
            w_add  = lu_add;
            w_data = lu_data;
         end
      end
   end

   assign lu_ready  = !rst && !full;
   assign stall_req = !rst && (starved || full);
   assign hazard    = !rst && ((rd1_en && busy_q[rd1_add]) ||
                               (rd2_en && busy_q[rd2_add]) ||
                               (iss_en && busy_q[iss_add]));

endmodule
